io_handshake_ctrl: RTL and testbench

Sequencer between the 8-bit CPU's level I/O port (output enable/value, input enable/value) and external valid/ready devices. It buffers CPU output bytes in a small FIFO and prefetches one input byte into a skid register. When the CPU's I/O instruction cannot complete in the current cycle, it asserts cpu_hold, which freezes the program counter and register saves. A hold timeout stops the CPU from deadlocking on a dead device.

---
 rtl/io_ctrl_pkg.sv | 17 +
 rtl/io_handshake_ctrl_if.sv | 36 +++
 rtl/io_sync_fifo.sv | 58 +++++
 rtl/io_handshake_ctrl.sv | 127 ++++++++++++
 tb/tb_io_handshake_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared types and constants for the CPU I/O handshake sequencer
// Purpose : sequencer state encoding, default data width, byte returned on a forced read.
// Ports   : none (package).
package io_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Byte handed to the CPU when no input byte is available or a read is forced.
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/io_handshake_ctrl_if.sv
// rtl/io_handshake_ctrl_if.sv - CPU level port plus device valid/ready bundle
// Purpose : groups every non-clock signal of io_handshake_ctrl.
// Ports   : slave  - the controller (CPU strobes, device handshakes and err_clr in; hold, data, status out)
//           master - the CPU/device side driving the controller
interface io_handshake_ctrl_if #(
    parameter int DATA_W      = 8,
    parameter int OFIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(OFIFO_DEPTH) + 1;

    logic              cpu_out_en;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_in_en;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_hold;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [LVL_W-1:0]  ofifo_level;
    logic              timeout_err;
    logic              err_clr;

    modport slave (
        input  cpu_out_en, cpu_out_data, cpu_in_en, out_ready, in_valid, in_data, err_clr,
        output cpu_in_data, cpu_hold, out_valid, out_data, in_ready, ofifo_level, timeout_err
    );

    modport master (
        output cpu_out_en, cpu_out_data, cpu_in_en, out_ready, in_valid, in_data, err_clr,
        input  cpu_in_data, cpu_hold, out_valid, out_data, in_ready, ofifo_level, timeout_err
    );

endinterface

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock FIFO with registered head and push-through-full
// Purpose : buffers CPU output bytes; a push is accepted when full if a pop happens the same cycle.
// Ports   : clk, rst (sync active-low); i_push/i_push_data write side; i_pop read side;
//           o_full, o_empty, o_level occupancy; o_head current head entry (storage flop).
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [WIDTH-1:0]           o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot at this edge, so a full FIFO can still take the push.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/io_handshake_ctrl.sv
// rtl/io_handshake_ctrl.sv - CPU level I/O port to valid/ready device sequencer
// Purpose : queues CPU output bytes, prefetches one input byte, stalls the CPU while its I/O
//           instruction cannot complete, and force-releases a stall after TIMEOUT cycles.
// Ports   : clk, rst (sync active-low); bus (io_handshake_ctrl_if.slave) carrying the CPU
//           strobes/data, cpu_hold, device out/in handshakes, ofifo_level, timeout_err, err_clr.
module io_handshake_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int OFIFO_DEPTH = 4,
    parameter int TIMEOUT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    io_handshake_ctrl_if.slave   bus
);
    localparam int LVL_W = $clog2(OFIFO_DEPTH) + 1;

    state_t            r_state;
    logic [31:0]       r_cnt;
    logic              r_err;
    logic              r_skid_full;
    logic [DATA_W-1:0] r_skid;

    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;
    logic [DATA_W-1:0] w_head;
    logic              w_pop;
    logic              w_out_blk;
    logic              w_in_blk;
    logic              w_blocked;
    logic              w_force;
    logic              w_push;
    logic              w_consume;
    logic              w_capture;
    logic              w_timeout;
    logic              w_to_release;

    assign w_pop     = ~w_empty & bus.out_ready;
    assign w_out_blk = bus.cpu_out_en & w_full & ~w_pop;
    assign w_in_blk  = bus.cpu_in_en & ~r_skid_full;
    assign w_blocked = w_out_blk | w_in_blk;
    // In RELEASE a still-blocked instruction is abandoned: no push, no consume, idle byte read.
    assign w_force   = (r_state == RELEASE) & w_blocked;
    // Both halves of a copy instruction complete together or not at all.
    assign w_push    = bus.cpu_out_en & ~w_blocked;
    assign w_consume = bus.cpu_in_en & ~w_blocked;
    assign w_capture = bus.in_valid & ~r_skid_full;

    // r_cnt counts STALL cycles already spent; the RUN cycle that raised hold is the first.
    assign w_timeout    = (TIMEOUT > 1) && (r_cnt == 32'(TIMEOUT - 2));
    assign w_to_release = w_blocked & (((r_state == RUN) & (TIMEOUT == 1)) |
                                       ((r_state == STALL) & w_timeout));

    assign bus.cpu_hold    = w_blocked & (r_state != RELEASE);
    assign bus.cpu_in_data = (r_skid_full & ~w_force) ? r_skid : DATA_W'(IDLE_BYTE);
    assign bus.out_valid   = ~w_empty;
    assign bus.out_data    = w_head;
    assign bus.in_ready    = ~r_skid_full;
    assign bus.ofifo_level = w_level;
    assign bus.timeout_err = r_err;

    io_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.cpu_out_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skid_full <= 1'b0;
            r_skid      <= '0;
        end else if (w_capture) begin
            r_skid_full <= 1'b1;
            r_skid      <= bus.in_data;
        end else if (w_consume) begin
            r_skid_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                RUN: begin
                    if (w_to_release) begin
                        r_state <= RELEASE;
                    end else if (w_blocked) begin
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    if (!w_blocked) begin
                        r_state <= RUN;
                    end else if (w_to_release) begin
                        r_state <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                RELEASE: r_state <= RUN;
                default: r_state <= RUN;
            endcase
            // Set on entry to and during RELEASE so a coincident clear cannot hide it.
            if (w_to_release || (r_state == RELEASE)) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// tb/tb_io_handshake_ctrl.sv - self-checking bench for io_handshake_ctrl
module tb_io_handshake_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    io_handshake_ctrl_if #(.DATA_W(DW), .OFIFO_DEPTH(DEPTH)) bus ();

    io_handshake_ctrl #(.DATA_W(DW), .OFIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: queue for the FIFO, one-entry skid, count of consecutive hold cycles.
    logic [7:0] mq[$];
    bit         m_valid;
    bit         m_skid_full;
    logic [7:0] m_skid;
    int         m_hold_len;
    bit         m_rel;
    bit         m_err;

    always @(negedge clk) begin
        bit         pop, oblk, iblk, blk, hold, frc, nrel;
        logic [7:0] exp_in;
        pop    = (mq.size() > 0) && bus.out_ready;
        oblk   = bus.cpu_out_en && (mq.size() == DEPTH) && !pop;
        iblk   = bus.cpu_in_en && !m_skid_full;
        blk    = oblk || iblk;
        hold   = blk && !m_rel;
        frc    = m_rel && blk;
        exp_in = (m_skid_full && !frc) ? m_skid : 8'h00;
        if (m_valid) begin
            chk("cpu_hold", 32'(bus.cpu_hold), 32'(hold));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
            chk("in_ready", 32'(bus.in_ready), 32'(!m_skid_full));
            chk("cpu_in_data", 32'(bus.cpu_in_data), 32'(exp_in));
            chk("ofifo_level", 32'(bus.ofifo_level), 32'(mq.size()));
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        end
        if (!rst) begin
            mq.delete();
            m_skid_full = 0;
            m_skid      = 8'h00;
            m_hold_len  = 0;
            m_rel       = 0;
            m_err       = 0;
            m_valid     = 1;
        end else if (m_valid) begin
            if (pop) void'(mq.pop_front());
            if (bus.cpu_out_en && !blk) mq.push_back(bus.cpu_out_data);
            if (bus.in_valid && !m_skid_full) begin
                m_skid_full = 1;
                m_skid      = bus.in_data;
            end else if (bus.cpu_in_en && !blk) begin
                m_skid_full = 0;
            end
            // Release follows the TO-th consecutive held cycle.
            nrel = hold && (TO != 0) && (m_hold_len + 1 == TO);
            if (nrel || m_rel) m_err = 1;
            else if (bus.err_clr) m_err = 0;
            m_hold_len = (hold && !nrel) ? m_hold_len + 1 : 0;
            m_rel      = nrel;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit oe, input logic [7:0] od, input bit ie,
                       input bit ordy, input bit iv, input logic [7:0] id);
        bus.cpu_out_en   = oe;
        bus.cpu_out_data = od;
        bus.cpu_in_en    = ie;
        bus.out_ready    = ordy;
        bus.in_valid     = iv;
        bus.in_data      = id;
    endtask

    initial begin
        int hold_cycles;
        n_pass = 0;
        n_total = 0;
        m_valid = 0;
        rst = 1'b0;
        bus.err_clr = 1'b0;
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hold", 32'(bus.cpu_hold), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_level", 32'(bus.ofifo_level), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);

        // Three pushes, then drain on consecutive cycles.
        step();
        drv(1, 8'h11, 0, 0, 0, 8'h00); step();
        drv(1, 8'h22, 0, 0, 0, 8'h00); step();
        drv(1, 8'h33, 0, 0, 0, 8'h00); step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("lvl3", 32'(bus.ofifo_level), 32'd3);
        step();
        drv(0, 8'h00, 0, 1, 0, 8'h00);
        @(negedge clk); chk("drain0", 32'(bus.out_data), 32'h11);
        step();
        @(negedge clk); chk("drain1", 32'(bus.out_data), 32'h22);
        step();
        @(negedge clk); chk("drain2", 32'(bus.out_data), 32'h33);
        step();
        @(negedge clk); chk("drained", 32'(bus.out_valid), 32'd0);

        // Full FIFO blocks a push until a pop makes room in the same cycle.
        step();
        for (int i = 1; i <= 4; i++) begin
            drv(1, 8'(i), 0, 0, 0, 8'h00);
            step();
        end
        drv(1, 8'h55, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("full_hold", 32'(bus.cpu_hold), 32'd1);
            step();
        end
        drv(1, 8'h55, 0, 1, 0, 8'h00);
        @(negedge clk); chk("pulse_hold", 32'(bus.cpu_hold), 32'd0);
        step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("pulse_lvl", 32'(bus.ofifo_level), 32'd4);
        chk("pulse_head", 32'(bus.out_data), 32'h02);
        step();
        drv(0, 8'h00, 0, 1, 0, 8'h00);
        repeat (5) step();

        // Read with empty skid stalls until a byte arrives.
        drv(0, 8'h00, 1, 0, 0, 8'h00);
        @(negedge clk); chk("rd_hold", 32'(bus.cpu_hold), 32'd1);
        step();
        drv(0, 8'h00, 1, 0, 1, 8'hA5);
        @(negedge clk); chk("rd_hold_t", 32'(bus.cpu_hold), 32'd1);
        step();
        drv(0, 8'h00, 1, 0, 0, 8'h00);
        @(negedge clk);
        chk("rd_t1_hold", 32'(bus.cpu_hold), 32'd0);
        chk("rd_t1_data", 32'(bus.cpu_in_data), 32'hA5);
        step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk); chk("rd_t2_ready", 32'(bus.in_ready), 32'd1);

        // Dead input device: exactly TO held cycles, then one release cycle.
        step();
        drv(0, 8'h00, 1, 0, 0, 8'h00);
        hold_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_hold) hold_cycles++;
            else break;
        end
        chk("to_len", 32'(hold_cycles), 32'd8);
        chk("to_data", 32'(bus.cpu_in_data), 32'h00);
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        @(negedge clk); chk("err_clr", 32'(bus.timeout_err), 32'd0);

        // Copy from full skid to a non-full FIFO completes without a stall.
        step();
        drv(1, 8'h77, 0, 0, 1, 8'h3C); step();
        drv(0, 8'h00, 0, 0, 0, 8'h00); step();
        drv(1, 8'h3C, 1, 0, 0, 8'h00);
        @(negedge clk);
        chk("copy_hold", 32'(bus.cpu_hold), 32'd0);
        chk("copy_data", 32'(bus.cpu_in_data), 32'h3C);
        step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("copy_lvl", 32'(bus.ofifo_level), 32'd2);
        chk("copy_skid", 32'(bus.in_ready), 32'd1);

        // Copy into a full FIFO stalls and leaves the skid byte alone.
        step();
        drv(1, 8'hA1, 0, 0, 1, 8'h99); step();
        drv(1, 8'hA2, 0, 0, 0, 8'h00); step();
        drv(1, 8'h99, 1, 0, 0, 8'h00);
        @(negedge clk); chk("cfull_hold", 32'(bus.cpu_hold), 32'd1);
        step();
        @(negedge clk);
        chk("cfull_hold2", 32'(bus.cpu_hold), 32'd1);
        chk("cfull_skid", 32'(bus.in_ready), 32'd0);
        step();

        // Reset in the middle of that stall.
        rst = 1'b0;
        step();
        rst = 1'b1;
        drv(1, 8'h99, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("rstst_hold", 32'(bus.cpu_hold), 32'd0);
        chk("rstst_lvl", 32'(bus.ofifo_level), 32'd0);
        chk("rstst_ready", 32'(bus.in_ready), 32'd1);
        chk("rstst_valid", 32'(bus.out_valid), 32'd0);
        step();
        drv(0, 8'h00, 0, 0, 0, 8'h00);

        // Randomized traffic with varying device pressure; the model checks every cycle.
        for (int blkn = 0; blkn < 12; blkn++) begin
            int p_oe, p_ie, p_or, p_iv;
            p_oe = $urandom_range(10, 90);
            p_ie = $urandom_range(10, 90);
            p_or = $urandom_range(0, 100);
            p_iv = $urandom_range(0, 100);
            for (int c = 0; c < 250; c++) begin
                step();
                drv(($urandom % 100) < p_oe, 8'($urandom), ($urandom % 100) < p_ie,
                    ($urandom % 100) < p_or, ($urandom % 100) < p_iv, 8'($urandom));
                bus.err_clr = ($urandom % 20) == 0;
                rst = !(($urandom % 300) == 0);
            end
        end
        step();
        rst = 1'b1;
        drv(0, 8'h00, 0, 0, 0, 8'h00);
        bus.err_clr = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
